// File: rtl/game_pkg.sv
// Shared game constants: gamestate codes, scheduler states and
// obstacle widths used across the obstacle lane blocks.
package game_pkg;

  localparam logic [1:0] UNBEGIN = 2'b00;
  localparam logic [1:0] RUNNING = 2'b01;
  localparam logic [1:0] DEAD    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_GAP    = 2'b01,
    S_MOVE   = 2'b10,
    S_FREEZE = 2'b11
  } sched_state_e;

  localparam logic [9:0] OBST_W_DEFAULT = 10'd100;
  localparam logic [9:0] OBST_W_SMALL   = 10'd40;
  localparam logic [9:0] OBST_W_LARGE   = 10'd160;

  // 2'b10 is not a legal code and is folded into Dead.
  function automatic logic is_dead(input logic [1:0] gs);
    return gs[1];
  endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_if.sv
// Control/status bundle between the game controller, the scheduler
// and the obstacle renderer.
interface obstacle_spawn_scheduler_if;
  logic [1:0]         gamestate;
  logic               frame_tick;
  logic [9:0]         obstacle_width;
  logic               spawn;
  logic signed [11:0] obstacle_x;
  logic               obstacle_active;
  logic [4:0]         scroll_speed;
  logic [1:0]         sched_state;

  modport master (
    input  gamestate,
    input  frame_tick,
    input  obstacle_width,
    output spawn,
    output obstacle_x,
    output obstacle_active,
    output scroll_speed,
    output sched_state
  );

  modport slave (
    output gamestate,
    output frame_tick,
    output obstacle_width,
    input  spawn,
    input  obstacle_x,
    input  obstacle_active,
    input  scroll_speed,
    input  sched_state
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, advancing when en is high.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = {1'b0, q_q[15:1]}
          ^ ({16{q_q[0]}} & 16'hB400);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle lane sequencer: random spawn gaps, per-frame scrolling
// and a play-time speed ramp.
module obstacle_spawn_scheduler
  import game_pkg::*;
#(
  parameter int          SCREEN_W          = 640,
  parameter int          MIN_GAP           = 20,
  parameter int          GAP_RAND_BITS     = 6,
  parameter int          SPEED_INIT        = 4,
  parameter int          SPEED_MAX         = 12,
  parameter int          SPEED_STEP_FRAMES = 600,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input logic                        clk,
  input logic                        rst,
  obstacle_spawn_scheduler_if.master bus
);

  localparam int FW = $clog2(SPEED_STEP_FRAMES);

  sched_state_e       state_q, state_d;
  logic [15:0]        lfsr;
  logic [15:0]        gap_q, gap_d, gap_load;
  logic [FW-1:0]      frm_q, frm_d;
  logic [4:0]         spd_q, spd_d;
  logic signed [11:0] x_q, x_d, x_next;
  logic signed [12:0] edge_sum;
  logic               act_q, act_d;
  logic               spawn_q, spawn_d;
  logic [9:0]         w_q, w_d;
  logic               clear, reload;
  logic               run, unbegin, dead, tick;
  logic               unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (bus.frame_tick),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:GAP_RAND_BITS];

  assign run     = (bus.gamestate == RUNNING);
  assign unbegin = (bus.gamestate == UNBEGIN);
  assign dead    = is_dead(bus.gamestate);
  assign tick    = bus.frame_tick;

  assign gap_load = 16'(MIN_GAP)
                  + 16'(lfsr[GAP_RAND_BITS-1:0]);

  // Exit test uses the post-move position, so x never passes -width.
  assign x_next   = x_q - $signed({7'd0, spd_q});
  assign edge_sum = $signed({x_next[11], x_next})
                  + $signed({3'd0, w_q});

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    frm_d   = frm_q;
    spd_d   = spd_q;
    x_d     = x_q;
    act_d   = act_q;
    spawn_d = 1'b0;
    w_d     = spawn_q ? bus.obstacle_width : w_q;
    clear   = 1'b0;
    reload  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_GAP;
          reload  = 1'b1;
        end
      end
      S_GAP, S_MOVE: begin
        if (unbegin) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (dead) begin
          state_d = S_FREEZE;
        end else if (tick) begin
          if (frm_q == FW'(SPEED_STEP_FRAMES - 1)) begin
            frm_d = '0;
            if (spd_q < 5'(SPEED_MAX))
              spd_d = spd_q + 5'd1;
          end else begin
            frm_d = frm_q + 1'b1;
          end
          if (state_q == S_GAP) begin
            if (gap_q != 16'd0) begin
              gap_d = gap_q - 16'd1;
            end else begin
              state_d = S_MOVE;
              spawn_d = 1'b1;
              x_d     = 12'(SCREEN_W);
              act_d   = 1'b1;
            end
          end else if (edge_sum <= 0) begin
            state_d = S_GAP;
            act_d   = 1'b0;
            x_d     = 12'(SCREEN_W);
            reload  = 1'b1;
          end else begin
            x_d = x_next;
          end
        end
      end
      S_FREEZE: begin
        if (unbegin) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (run) begin
          state_d = S_GAP;
          clear   = 1'b1;
          reload  = 1'b1;
        end
      end
      default: ;
    endcase
    if (clear) begin
      x_d   = 12'(SCREEN_W);
      act_d = 1'b0;
      spd_d = 5'(SPEED_INIT);
      gap_d = '0;
      frm_d = '0;
      w_d   = OBST_W_DEFAULT;
    end
    if (reload) gap_d = gap_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      frm_q   <= '0;
      spd_q   <= 5'(SPEED_INIT);
      x_q     <= 12'(SCREEN_W);
      act_q   <= 1'b0;
      spawn_q <= 1'b0;
      w_q     <= OBST_W_DEFAULT;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      frm_q   <= frm_d;
      spd_q   <= spd_d;
      x_q     <= x_d;
      act_q   <= act_d;
      spawn_q <= spawn_d;
      w_q     <= w_d;
    end
  end

  assign bus.spawn           = spawn_q;
  assign bus.obstacle_x      = x_q;
  assign bus.obstacle_active = act_q;
  assign bus.scroll_speed    = spd_q;
  assign bus.sched_state     = state_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Bench for obstacle_spawn_scheduler: directed scenarios plus a
// randomized run against a frame-level behavioural model.
module tb_obstacle_spawn_scheduler;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obstacle_spawn_scheduler_if bus();

  obstacle_spawn_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int tk;

  // Model: game-level view of the lane, in plain integers.
  int m_st, m_x, m_act, m_spd, m_gap, m_frm, m_w, m_spawn;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic model_clear();
    m_x = 640; m_act = 0; m_spd = 4;
    m_gap = 0; m_frm = 0; m_w = 100;
  endtask

  task automatic model_reset();
    model_clear();
    m_st = 0; m_spawn = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic [1:0] gs, input bit t,
                            input int w);
    logic [15:0] cur;
    int load, nx, was_spawn, old_w;
    cur = m_lfsr;
    load = 20 + int'(cur[5:0]);
    was_spawn = m_spawn;
    old_w = m_w;
    m_spawn = 0;
    if (was_spawn != 0) m_w = w;
    case (m_st)
      0: if (gs == 2'b01) begin m_st = 1; m_gap = load; end
      1, 2: begin
        if (gs == 2'b00) begin
          model_clear(); m_st = 0;
        end else if (gs[1]) begin
          m_st = 3;
        end else if (t) begin
          nx = m_x - m_spd;
          m_frm++;
          if (m_frm == 600) begin
            m_frm = 0;
            if (m_spd < 12) m_spd++;
          end
          if (m_st == 1) begin
            if (m_gap > 0) m_gap--;
            else begin
              m_st = 2; m_spawn = 1; m_x = 640; m_act = 1;
            end
          end else if (nx + old_w <= 0) begin
            m_st = 1; m_act = 0; m_x = 640; m_gap = load;
          end else begin
            m_x = nx;
          end
        end
      end
      default: begin
        if (gs == 2'b00) begin
          model_clear(); m_st = 0;
        end else if (gs == 2'b01) begin
          model_clear(); m_st = 1; m_gap = load;
        end
      end
    endcase
    if (t) m_lfsr = lfsr_adv(cur);
  endtask

  task automatic cycle(input logic [1:0] gs, input bit t);
    bus.gamestate  = gs;
    bus.frame_tick = t;
    model_step(gs, t, int'(bus.obstacle_width));
    @(posedge clk);
    #1;
    if (t) tk++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.sched_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", bus.sched_state);
    end
    checks++;
    if (bus.spawn !== 1'b0) begin
      errors++;
      $display("FAIL reset_spawn: got %0b want 0", bus.spawn);
    end
    checks++;
    if (bus.obstacle_x !== 12'sd640) begin
      errors++;
      $display("FAIL reset_x: got %0d want 640", bus.obstacle_x);
    end
    checks++;
    if (bus.obstacle_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: got %0b want 0",
               bus.obstacle_active);
    end
    checks++;
    if (bus.scroll_speed !== 5'd4) begin
      errors++;
      $display("FAIL reset_speed: got %0d want 4", bus.scroll_speed);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_spawn();
    int sp_tick;
    sp_tick = -1;
    tk = 0;
    for (int c = 0; c < 2000 && sp_tick < 0; c++) begin
      cycle(RUNNING, (c % 10) == 9);
      if (bus.spawn === 1'b1) sp_tick = tk;
    end
    checks++;
    if (sp_tick != 54) begin
      errors++;
      $display("FAIL spawn_tick: got %0d want 54", sp_tick);
    end
    checks++;
    if (bus.obstacle_x !== 12'sd640 || bus.obstacle_active !== 1'b1) begin
      errors++;
      $display("FAIL spawn_pos: got x=%0d act=%0b want x=640 act=1",
               bus.obstacle_x, bus.obstacle_active);
    end
    cycle(RUNNING, 1'b0);
    checks++;
    if (bus.spawn !== 1'b0) begin
      errors++;
      $display("FAIL spawn_width: got %0b want 0 one clk later",
               bus.spawn);
    end
  endtask

  task automatic test_move_exit();
    int mv;
    mv = 0;
    for (int c = 0; c < 4000 && bus.obstacle_active === 1'b1; c++) begin
      cycle(RUNNING, (c % 10) == 9);
      if ((c % 10) == 9) begin
        mv++;
        if (bus.obstacle_active === 1'b1) begin
          checks++;
          if (bus.obstacle_x !== 12'(640 - 4 * mv)) begin
            errors++;
            $display("FAIL move_step%0d: got %0d want %0d", mv,
                     bus.obstacle_x, 640 - 4 * mv);
          end
        end
      end
    end
    checks++;
    if (mv != 185) begin
      errors++;
      $display("FAIL exit_tick: got %0d want 185", mv);
    end
    checks++;
    if (bus.sched_state !== 2'b01 || bus.obstacle_x !== 12'sd640) begin
      errors++;
      $display("FAIL exit_state: got st=%0d x=%0d want st=1 x=640",
               bus.sched_state, bus.obstacle_x);
    end
  endtask

  task automatic test_speed_ramp();
    int want;
    for (int c = 0; c < 20000 && tk < 6000; c++) begin
      bus.obstacle_width = 10'($urandom_range(20, 300));
      cycle(RUNNING, (c % 2) == 1);
      if ((c % 2) == 1) begin
        want = -1;
        if (tk == 599) want = 4;
        if (tk == 600) want = 5;
        if (tk == 4800 || tk == 6000) want = 12;
        if (want >= 0) begin
          checks++;
          if (bus.scroll_speed !== 5'(want)) begin
            errors++;
            $display("FAIL speed_at_%0d: got %0d want %0d", tk,
                     bus.scroll_speed, want);
          end
        end
        checks++;
        if (bus.obstacle_x !== 12'(m_x)) begin
          errors++;
          $display("FAIL ramp_x_at_%0d: got %0d want %0d", tk,
                   bus.obstacle_x, m_x);
        end
      end
    end
    checks++;
    if (tk != 6000) begin
      errors++;
      $display("FAIL ramp_budget: got %0d ticks want 6000", tk);
    end
  endtask

  task automatic test_freeze();
    logic signed [11:0] x0;
    bit hit;
    hit = 0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      cycle(RUNNING, (c % 2) == 1);
      hit = (bus.sched_state === 2'b10) && (bus.obstacle_x < 400);
    end
    x0 = bus.obstacle_x;
    cycle(DEAD, 1'b1);
    checks++;
    if (!hit || bus.obstacle_x !== x0 || bus.spawn !== 1'b0
        || bus.sched_state !== 2'b11) begin
      errors++;
      $display("FAIL dead_priority: got x=%0d sp=%0b st=%0d want x=%0d sp=0 st=3",
               bus.obstacle_x, bus.spawn, bus.sched_state, x0);
    end
    for (int i = 0; i < 20; i++)
      cycle((i % 2) ? 2'b10 : DEAD, 1'b1);
    checks++;
    if (bus.obstacle_x !== x0 || bus.sched_state !== 2'b11
        || bus.scroll_speed !== 5'd12 || bus.obstacle_active !== 1'b1) begin
      errors++;
      $display("FAIL freeze_hold: got x=%0d st=%0d spd=%0d act=%0b want x=%0d st=3 spd=12 act=1",
               bus.obstacle_x, bus.sched_state, bus.scroll_speed,
               bus.obstacle_active, x0);
    end
  endtask

  task automatic test_unbegin_restart();
    int exp_gap, n;
    bit sp;
    cycle(UNBEGIN, 1'b0);
    checks++;
    if (bus.sched_state !== 2'b00 || bus.obstacle_x !== 12'sd640
        || bus.scroll_speed !== 5'd4 || bus.obstacle_active !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: got st=%0d x=%0d spd=%0d act=%0b want 0/640/4/0",
               bus.sched_state, bus.obstacle_x, bus.scroll_speed,
               bus.obstacle_active);
    end
    repeat (5) cycle(UNBEGIN, 1'b1);
    bus.obstacle_width = 10'd100;
    cycle(RUNNING, 1'b0);
    exp_gap = m_gap;
    n = 0;
    sp = 0;
    for (int c = 0; c < 400 && !sp; c++) begin
      cycle(RUNNING, 1'b1);
      n++;
      sp = (bus.spawn === 1'b1);
    end
    checks++;
    if (!sp || n != exp_gap + 1) begin
      errors++;
      $display("FAIL restart_gap: got %0d ticks want %0d", n, exp_gap + 1);
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      cycle(RUNNING, 1'b1);
      hit = (bus.sched_state === 2'b10) && (bus.obstacle_x === 12'sd200);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!hit || bus.sched_state !== 2'b00 || bus.spawn !== 1'b0
        || bus.obstacle_x !== 12'sd640 || bus.obstacle_active !== 1'b0
        || bus.scroll_speed !== 5'd4) begin
      errors++;
      $display("FAIL async_rst: got st=%0d x=%0d act=%0b spd=%0d want 0/640/0/4",
               bus.sched_state, bus.obstacle_x, bus.obstacle_active,
               bus.scroll_speed);
    end
    checks++;
    if (dut.u_lfsr.q_q !== 16'hACE1) begin
      errors++;
      $display("FAIL async_lfsr: got %h want ace1", dut.u_lfsr.q_q);
    end
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0]  gs;
    logic [20:0] got, exp;
    gs = RUNNING;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0)
        gs = $urandom_range(0, 1) ? RUNNING : 2'($urandom_range(0, 3));
      bus.obstacle_width = 10'($urandom_range(8, 400));
      cycle(gs, $urandom_range(0, 2) == 0);
      got = {bus.sched_state, bus.spawn, bus.obstacle_x,
             bus.obstacle_active, bus.scroll_speed};
      exp = {2'(m_st), 1'(m_spawn), 12'(m_x), 1'(m_act), 5'(m_spd)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_c%0d: got %h want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    bus.gamestate = UNBEGIN;
    bus.frame_tick = 1'b0;
    bus.obstacle_width = 10'd100;
    tk = 0;
    test_reset();
    test_first_spawn();
    test_move_exit();
    test_speed_ramp();
    test_freeze();
    test_unbegin_restart();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
